// File: rtl/lock_entry_controller.sv
// lock_entry_controller: keypad entry sequencer for the digital lock.
// Collects four one-hot key presses, shows them on digit3..digit0, checks
// them against CODE and runs the UNLOCKED / ERROR windows and the inter-key
// timeout. Optional feature macro: LOCKOUT_EN (lockout after MAX_FAILS
// consecutive failures). When it is undefined, LOCKOUT is unreachable and
// locked_out is tied low.
`timescale 1ns/1ps
module lock_entry_controller #(
   parameter logic [15:0] CODE           = 16'h8421,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000,
   parameter logic [31:0] UNLOCK_CYCLES  = 32'd500_000_000,
   parameter logic [31:0] ERROR_CYCLES   = 32'd100_000_000,
   parameter logic [1:0]  MAX_FAILS      = 2'd3,
   parameter logic [31:0] LOCKOUT_CYCLES = 32'd1_500_000_000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] KEY,
   input  logic       lock,
   output logic [3:0] digit3,
   output logic [3:0] digit2,
   output logic [3:0] digit1,
   output logic [3:0] digit0,
   output logic       unlocked,
   output logic       error,
   output logic       locked_out,
   output logic [1:0] fail_count,
   output logic [2:0] state
);

`ifdef LOCKOUT_EN
   localparam bit LOCKOUT_ON = 1'b1;
`else
   localparam bit LOCKOUT_ON = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ENTRY    = 3'd1,
      S_CHECK    = 3'd2,
      S_UNLOCKED = 3'd3,
      S_ERROR    = 3'd4,
      S_LOCKOUT  = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] digits_q, digits_d;   // {digit3, digit2, digit1, digit0}
   logic [1:0]  fail_q, fail_d;
   logic [3:0]  key_prev;
   logic        unlocked_q, error_q;
   logic        key_onehot, press;

   // A press is a clean one-hot KEY after a cycle with no key down, so a
   // held key or a multi-key chord never produces a second event.
   assign key_onehot = (KEY == 4'b0001) || (KEY == 4'b0010) ||
                       (KEY == 4'b0100) || (KEY == 4'b1000);
   assign press      = key_onehot && (key_prev == 4'b0000);

   // Next-state and datapath updates; timer free-runs unless a branch clears it.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q + 32'd1;
      idx_d    = idx_q;
      digits_d = digits_q;
      fail_d   = fail_q;
      case (state_q)
         S_IDLE: begin
            timer_d  = '0;
            digits_d = '0;
            idx_d    = '0;
            if (press) begin
               digits_d = {KEY, 12'h000};
               idx_d    = 2'd1;
               state_d  = S_ENTRY;
            end
         end
         S_ENTRY: begin
            if (press) begin
               // press beats a coincident timeout
               timer_d = '0;
               idx_d   = idx_q + 2'd1;
               case (idx_q)
                  2'd1: digits_d[11:8] = KEY;
                  2'd2: digits_d[7:4]  = KEY;
                  2'd3: begin
                     digits_d[3:0] = KEY;
                     state_d       = S_CHECK;
                  end
                  default: ;
               endcase
            end else if (timer_q == TIMEOUT_CYCLES - 32'd1) begin
               timer_d  = '0;
               digits_d = '0;
               idx_d    = '0;
               state_d  = S_IDLE;
            end
         end
         S_CHECK: begin
            timer_d = '0;
            if (digits_q == CODE) begin
               fail_d  = '0;
               state_d = S_UNLOCKED;
            end else begin
               if (fail_q != 2'd3) fail_d = fail_q + 2'd1;
               state_d = S_ERROR;
            end
         end
         S_UNLOCKED: begin
            if (lock || (timer_q == UNLOCK_CYCLES - 32'd1)) begin
               timer_d  = '0;
               digits_d = '0;
               idx_d    = '0;
               state_d  = S_IDLE;
            end
         end
         S_ERROR: begin
            if (timer_q == ERROR_CYCLES - 32'd1) begin
               timer_d  = '0;
               digits_d = '0;
               idx_d    = '0;
               state_d  = (LOCKOUT_ON && (fail_q >= MAX_FAILS)) ? S_LOCKOUT : S_IDLE;
            end
         end
         S_LOCKOUT: begin
            if (timer_q == LOCKOUT_CYCLES - 32'd1) begin
               timer_d = '0;
               fail_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            timer_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered flags; flags track the next state so they
   // line up with the registered state output.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         idx_q      <= '0;
         digits_q   <= '0;
         fail_q     <= '0;
         key_prev   <= '0;
         unlocked_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         idx_q      <= idx_d;
         digits_q   <= digits_d;
         fail_q     <= fail_d;
         key_prev   <= KEY;
         unlocked_q <= (state_d == S_UNLOCKED);
         error_q    <= (state_d == S_ERROR);
      end
   end

`ifdef LOCKOUT_EN
   logic locked_out_q;

   // Lockout flag, registered alongside the other window flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) locked_out_q <= 1'b0;
      else          locked_out_q <= (state_d == S_LOCKOUT);
   end

   assign locked_out = locked_out_q;
`else
   assign locked_out = 1'b0;
`endif

   assign digit3     = digits_q[15:12];
   assign digit2     = digits_q[11:8];
   assign digit1     = digits_q[7:4];
   assign digit0     = digits_q[3:0];
   assign unlocked   = unlocked_q;
   assign error      = error_q;
   assign fail_count = fail_q;
   assign state      = state_q;

endmodule

// File: tb/tb_lock_entry_controller.sv
// Bench for lock_entry_controller with short windows (TIMEOUT=20, UNLOCK=10,
// ERROR=5, LOCKOUT=8). Entries push their expected outcome to a scoreboard
// queue; the outcome is popped and compared once the DUT reaches CHECK.
`timescale 1ns/1ps
module tb_lock_entry_controller;
   localparam logic [15:0] CODE = 16'h8421;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [3:0] KEY;
   logic       lock;
   logic [3:0] digit3, digit2, digit1, digit0;
   logic       unlocked, error, locked_out;
   logic [1:0] fail_count;
   logic [2:0] state;
   logic [15:0] digs;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] digits;
      bit          unl;
      logic [1:0]  fail;
   } exp_t;
   exp_t sb[$];

   assign digs = {digit3, digit2, digit1, digit0};

   lock_entry_controller #(
      .CODE(CODE), .TIMEOUT_CYCLES(32'd20), .UNLOCK_CYCLES(32'd10),
      .ERROR_CYCLES(32'd5), .MAX_FAILS(2'd3), .LOCKOUT_CYCLES(32'd8)
   ) dut (
      .clock(clock), .reset_n(reset_n), .KEY(KEY), .lock(lock),
      .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
      .unlocked(unlocked), .error(error), .locked_out(locked_out),
      .fail_count(fail_count), .state(state)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [3:0] k, input int hold, input int gap);
      KEY = k;
      repeat (hold) tick;
      KEY = 4'b0000;
      repeat (gap) tick;
   endtask

   // Last press of an entry, then measure the result window.
   task automatic finish_entry(input logic [3:0] k, input logic [2:0] exp_next);
      exp_t e;
      int   n;
      KEY = k;
      tick;
      e = sb.pop_front();
      checks++;
      if (state !== 3'd2) begin errors++; $display("FAIL check_state: got %0d expected 2", state); end
      checks++;
      if (digs !== e.digits) begin errors++; $display("FAIL entry_digits: got %h expected %h", digs, e.digits); end
      n = 0;
      for (int c = 0; c < 40; c++) begin
         tick;
         if (c == 1) KEY = 4'b0000;
         if (!(e.unl ? unlocked : error)) break;
         n++;
      end
      KEY = 4'b0000;
      checks++;
      if (n != (e.unl ? 10 : 5)) begin errors++; $display("FAIL window_len: got %0d expected %0d", n, e.unl ? 10 : 5); end
      checks++;
      if (fail_count !== e.fail) begin errors++; $display("FAIL fail_count: got %0d expected %0d", fail_count, e.fail); end
      checks++;
      if (state !== exp_next) begin errors++; $display("FAIL post_state: got %0d expected %0d", state, exp_next); end
      checks++;
      if (digs !== 16'h0) begin errors++; $display("FAIL post_digits: got %h expected 0000", digs); end
   endtask

   task automatic enter_code(input logic [15:0] code, input bit unl, input logic [1:0] fail,
                             input logic [2:0] exp_next);
      logic [15:0] m;
      sb.push_back('{digits: code, unl: unl, fail: fail});
      for (int i = 0; i < 3; i++) begin
         press(code[15-4*i -: 4], 3, 2);
         m = 16'hFFFF;
         m = ~(m >> (4 * (i + 1)));
         checks++;
         if (digs !== (code & m)) begin errors++; $display("FAIL partial_digits: got %h expected %h", digs, code & m); end
         checks++;
         if (state !== 3'd1) begin errors++; $display("FAIL entry_state: got %0d expected 1", state); end
      end
      finish_entry(code[3:0], exp_next);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      KEY     = 4'b0000;
      lock    = 1'b0;
      #1;
      checks++;
      if ({state, digs, unlocked, error, locked_out, fail_count} !== 24'h0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", {state, digs, unlocked, error, locked_out, fail_count});
      end
      repeat (3) tick;
      reset_n = 1'b1;
      repeat (2) tick;
      checks++;
      if (state !== 3'd0) begin errors++; $display("FAIL idle_after_reset: got %0d expected 0", state); end
   endtask

   task automatic test_correct;
      enter_code(CODE, 1'b1, 2'd0, 3'd0);
   endtask

   task automatic test_wrong;
      enter_code(16'h1248, 1'b0, 2'd1, 3'd0);
      enter_code(CODE, 1'b1, 2'd0, 3'd0);
   endtask

   task automatic test_key_hygiene;
      lock = 1'b1;   // relock request must be ignored outside UNLOCKED
      KEY = 4'b1000;
      repeat (10) tick;
      KEY = 4'b0000;
      tick;
      checks++;
      if (digs !== 16'h8000) begin errors++; $display("FAIL hold_one_event: got %h expected 8000", digs); end
      KEY = 4'b0011;
      repeat (2) tick;
      KEY = 4'b0100;   // no return to 0 after the chord: no event
      repeat (2) tick;
      checks++;
      if (digs !== 16'h8000) begin errors++; $display("FAIL chord_ignored: got %h expected 8000", digs); end
      KEY = 4'b0000;
      tick;
      KEY = 4'b0100;
      tick;
      checks++;
      if (digs !== 16'h8400) begin errors++; $display("FAIL store_after_release: got %h expected 8400", digs); end
      KEY = 4'b0000;
      lock = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (state === 3'd0) break;
         tick;
      end
      checks++;
      if ({state, digs} !== 19'h0) begin errors++; $display("FAIL hygiene_timeout: got %h expected 0", {state, digs}); end
   endtask

   task automatic test_timeout;
      enter_code(16'h1248, 1'b0, 2'd1, 3'd0);
      KEY = 4'b1000;
      tick;
      KEY = 4'b0000;
      repeat (19) tick;
      checks++;
      if (state !== 3'd1) begin errors++; $display("FAIL before_timeout: got %0d expected 1", state); end
      KEY = 4'b0100;   // press on the timeout cycle wins
      tick;
      KEY = 4'b0000;
      checks++;
      if ({state, digs} !== {3'd1, 16'h8400}) begin errors++; $display("FAIL press_at_timeout: got %h expected %h", {state, digs}, {3'd1, 16'h8400}); end
      repeat (19) tick;
      checks++;
      if (state !== 3'd1) begin errors++; $display("FAIL timer_restart: got %0d expected 1", state); end
      tick;
      checks++;
      if ({state, digs} !== 19'h0) begin errors++; $display("FAIL timeout_clear: got %h expected 0", {state, digs}); end
      checks++;
      if (fail_count !== 2'd1) begin errors++; $display("FAIL timeout_fail_count: got %0d expected 1", fail_count); end
      enter_code(CODE, 1'b1, 2'd0, 3'd0);
   endtask

   task automatic test_relock;
      press(4'b1000, 3, 2);
      press(4'b0100, 3, 2);
      press(4'b0010, 3, 2);
      KEY = 4'b0001;
      tick;
      checks++;
      if (state !== 3'd2) begin errors++; $display("FAIL relock_check: got %0d expected 2", state); end
      tick;
      KEY = 4'b0000;
      tick;
      tick;
      checks++;
      if ({state, unlocked} !== {3'd3, 1'b1}) begin errors++; $display("FAIL unlocked_cycle3: got %h expected %h", {state, unlocked}, {3'd3, 1'b1}); end
      lock = 1'b1;
      tick;
      lock = 1'b0;
      checks++;
      if ({state, unlocked, digs} !== 20'h0) begin errors++; $display("FAIL relock_exit: got %h expected 0", {state, unlocked, digs}); end
   endtask

   task automatic test_async_reset;
      enter_code(16'h1248, 1'b0, 2'd1, 3'd0);
      press(4'b1000, 3, 2);
      press(4'b0100, 3, 2);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({state, digs, unlocked, error, locked_out, fail_count} !== 24'h0) begin
         errors++; $display("FAIL async_reset: got %h expected 0", {state, digs, unlocked, error, locked_out, fail_count});
      end
      repeat (2) tick;
      reset_n = 1'b1;
      tick;
   endtask

   task automatic test_lockout;
      int n;
      bit stored;
      enter_code(16'h1248, 1'b0, 2'd1, 3'd0);
      enter_code(16'h4812, 1'b0, 2'd2, 3'd0);
`ifdef LOCKOUT_EN
      enter_code(16'h2184, 1'b0, 2'd3, 3'd5);
      n = 0;
      stored = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (!locked_out) break;
         n++;
         if (c == 2) KEY = 4'b1000;
         if (c == 4) KEY = 4'b0000;
         if (digs !== 16'h0) stored = 1'b1;
         tick;
      end
      checks++;
      if (n != 8) begin errors++; $display("FAIL lockout_len: got %0d expected 8", n); end
      checks++;
      if (stored) begin errors++; $display("FAIL lockout_key_ignored: got stored expected none"); end
      checks++;
      if ({state, fail_count} !== 5'h0) begin errors++; $display("FAIL lockout_exit: got %h expected 0", {state, fail_count}); end
`else
      enter_code(16'h2184, 1'b0, 2'd3, 3'd0);
      checks++;
      if (locked_out !== 1'b0) begin errors++; $display("FAIL no_lockout: got %b expected 0", locked_out); end
      enter_code(16'h1111, 1'b0, 2'd3, 3'd0);
      enter_code(CODE, 1'b1, 2'd0, 3'd0);
`endif
   endtask

   initial begin
      test_reset;
      test_correct;
      test_wrong;
      test_key_hygiene;
      test_timeout;
      test_relock;
      test_async_reset;
      test_lockout;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
